// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to uart_tx and uart_rx),
// baud counter width and the idle line level.
package uart_pkg;

  localparam int   CNT_W      = 16;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// RXD input conditioning: 2-FF synchronizer, one history FF and a falling-edge
// pulse. All stages reset to the idle level so reset never fakes a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // NOTE: sequential state uses <= so every stage samples its pre-edge input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      hist_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rxd_s = sync2_q;
  assign fall  = hist_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity
// (macro UART_RX_PARITY_EN), one stop bit; bit period from runtime uart_cnt.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      uart_cnt,
  input  logic                  uart_rxd,
  output logic [DATA_WIDTH-1:0] uart_data,
  output logic                  uart_flag,
  output logic                  uart_busy,
  output logic                  uart_ferr,
  output logic                  uart_perr
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx: DATA_WIDTH must be 5..9 and PARITY_ODD 0 or 1");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
  logic par_bad_q, par_bad_d;
  logic perr_q,    perr_d;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      bps_cnt_q, bps_cnt_d;
  logic [CNT_W-1:0]      cnt_lat_q, cnt_lat_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  flag_q,    flag_d;
  logic                  ferr_q,    ferr_d;
  logic                  rxd_s, fall, tick;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (uart_rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  assign tick = (bps_cnt_q == '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    bps_cnt_d = bps_cnt_q;
    cnt_lat_d = cnt_lat_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    flag_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP} && !tick)
      bps_cnt_d = bps_cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_lat_d = uart_cnt;
          bps_cnt_d = (uart_cnt >> 1) - 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            bps_cnt_d = cnt_lat_q - 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d   = {rxd_s, shreg_q[DATA_WIDTH-1:1]};
          bps_cnt_d = cnt_lat_q - 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          par_bad_d = rxd_s ^ (^shreg_q) ^ PARITY_ODD[0];
          bps_cnt_d = cnt_lat_q - 1'b1;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop lets a shortened transmitter stop bit chain frames.
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
`endif
          if (rxd_s) begin
            data_d  = shreg_q;
            flag_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bps_cnt_q <= '0;
      cnt_lat_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      flag_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bps_cnt_q <= bps_cnt_d;
      cnt_lat_q <= cnt_lat_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
  assign uart_perr = perr_q;
`else
  assign uart_perr = 1'b0;
`endif

  assign uart_data = data_q;
  assign uart_flag = flag_q;
  assign uart_ferr = ferr_q;
  assign uart_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model driven from the recorded
// pin history, per-cycle compare, directed scenarios plus randomized frames.
module tb_uart_rx;

  localparam int W          = 8;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [15:0]   uart_cnt = 16'd16;
  logic          uart_rxd = 1'b1;
  logic [W-1:0]  uart_data;
  logic          uart_flag, uart_busy, uart_ferr, uart_perr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(W), .PARITY_ODD(PARITY_ODD)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_cnt  (uart_cnt),
    .uart_rxd  (uart_rxd),
    .uart_data (uart_data),
    .uart_flag (uart_flag),
    .uart_busy (uart_busy),
    .uart_ferr (uart_ferr),
    .uart_perr (uart_perr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pin level of interval j (after posedge j) is hist[j]. The receiver sees
  // interval j at posedge j+3 (two sync stages, then the FSM register), so a
  // start detected at posedge s0 with period n samples element idx at posedge
  // s0 + n/2 + idx*n, reading the pin level three intervals earlier.
  typedef enum {M_IDLE, M_FRAME, M_BREAK} mmode_e;
  mmode_e       mode      = M_IDLE;
  bit           hist [0:65535];
  int           cyc       = 0;
  int           floor_c   = 0;
  int           s0        = 0;
  int           fn        = 16;
  logic [W-1:0] m_byte    = '0;
  logic [W-1:0] m_data    = '0;
  bit           m_par_bad = 1'b0;
  logic         e_flag = 1'b0, e_ferr = 1'b0, e_perr = 1'b0, e_busy = 1'b0;
  logic         rst_prev  = 1'b1;
  logic [15:0]  cnt_prev  = 16'd16;
  int           flag_cnt = 0, ferr_cnt = 0, perr_cnt = 0, busy_cnt = 0;
  logic [W-1:0] rx_q [$];

  function automatic bit h(input int j);
    if (j < floor_c || j < 0 || j > 65535) return 1'b1;
    return hist[j];
  endfunction

  always @(negedge clk) begin
    int rel;
    int idx;
    bit v;
    cyc++;
    if (cyc <= 65535) hist[cyc] = uart_rxd;
    e_flag = 1'b0;
    e_ferr = 1'b0;
    e_perr = 1'b0;
    if (rst_prev) begin
      mode    = M_IDLE;
      m_data  = '0;
      floor_c = cyc;
    end else begin
      case (mode)
        M_IDLE: begin
          if (h(cyc - 4) && !h(cyc - 3)) begin
            mode      = M_FRAME;
            s0        = cyc;
            fn        = int'(cnt_prev);
            m_par_bad = 1'b0;
          end
        end
        M_FRAME: begin
          rel = cyc - s0 - (fn / 2);
          if (rel >= 0 && (rel % fn) == 0) begin
            idx = rel / fn;
            v   = h(cyc - 3);
            if (idx == 0) begin
              if (v) mode = M_IDLE;
            end else if (idx <= W) begin
              m_byte[idx-1] = v;
            end else if (P && idx == W + 1) begin
              m_par_bad = v ^ (^m_byte) ^ PARITY_ODD[0];
            end else begin
              e_perr = P & m_par_bad;
              if (v) begin
                m_data = m_byte;
                e_flag = 1'b1;
                mode   = M_IDLE;
              end else begin
                e_ferr = 1'b1;
                mode   = M_BREAK;
              end
            end
          end
        end
        M_BREAK: if (h(cyc - 3)) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    e_busy = (mode != M_IDLE);

    check("flag", uart_flag, e_flag);
    check("ferr", uart_ferr, e_ferr);
    check("perr", uart_perr, e_perr);
    check("busy", uart_busy, e_busy);
    check("data", uart_data, m_data);

    if (uart_flag === 1'b1) begin
      flag_cnt++;
      rx_q.push_back(uart_data);
    end
    if (uart_ferr === 1'b1) ferr_cnt++;
    if (uart_perr === 1'b1) perr_cnt++;
    if (uart_busy === 1'b1) busy_cnt++;
    rst_prev = rst;
    cnt_prev = uart_cnt;
  end

  // ---------------- stimulus ----------------
  // Each drive starts just after a rising edge and holds for len clocks.
  task automatic drive_bit(input logic v, input int len);
    uart_rxd = v;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] b, input int n, input bit stop_ok,
                            input int stop_len, input bit par_bad, input bit chg);
    logic pb;
    pb = (^b) ^ PARITY_ODD[0] ^ par_bad;
    drive_bit(1'b0, n);
    for (int i = 0; i < W; i++) begin
      drive_bit(b[i], n);
      if (chg && i == 2) uart_cnt = 16'($urandom_range(4, 60));
    end
    if (P) drive_bit(pb, n);
    drive_bit(stop_ok, stop_len);
  endtask

  initial begin
    int           f0, e0, p0, b0, q0;
    logic [W-1:0] b;
    logic [W-1:0] exp_bytes [3];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_data", uart_data, 0);
    check("reset_flag", uart_flag, 0);
    check("reset_busy", uart_busy, 0);
    check("reset_ferr", uart_ferr, 0);
    check("reset_perr", uart_perr, 0);

    // 1: clean 0x55 at 16 clocks per bit
    drive_bit(1'b1, 8);
    f0 = flag_cnt; e0 = ferr_cnt;
    send_frame(8'h55, 16, 1'b1, 16, 1'b0, 1'b0);
    drive_bit(1'b1, 20);
    check("t1_flags", flag_cnt - f0, 1);
    check("t1_data", uart_data, 8'h55);
    check("t1_ferr", ferr_cnt - e0, 0);

    // 2: 3-clock glitch is a false start: busy for n/2 clocks only
    f0 = flag_cnt; e0 = ferr_cnt; b0 = busy_cnt;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    check("t2_busy_len", busy_cnt - b0, 8);
    check("t2_flags", flag_cnt - f0, 0);
    check("t2_ferr", ferr_cnt - e0, 0);

    // 3: framing error followed by a long break, then a good frame
    f0 = flag_cnt; e0 = ferr_cnt;
    send_frame(8'hA3, 16, 1'b0, 16, 1'b0, 1'b0);
    drive_bit(1'b0, 40 * 16);
    drive_bit(1'b1, 30);
    check("t3_ferr", ferr_cnt - e0, 1);
    check("t3_flags", flag_cnt - f0, 0);
    check("t3_data_kept", uart_data, 8'h55);
    send_frame(8'h3C, 16, 1'b1, 16, 1'b0, 1'b0);
    drive_bit(1'b1, 20);
    check("t3_flags_after", flag_cnt - f0, 1);
    check("t3_data_after", uart_data, 8'h3C);

    // 4: back-to-back frames with 15/16-length stop bits at 434 clocks per bit
    uart_cnt = 16'd434;
    drive_bit(1'b1, 10);
    q0 = rx_q.size();
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h81;
    for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 434, 1'b1, 406, 1'b0, 1'b0);
    drive_bit(1'b1, 434);
    check("t4_count", rx_q.size() - q0, 3);
    for (int i = 0; i < 3; i++)
      check("t4_byte", (q0 + i < rx_q.size()) ? rx_q[q0 + i] : 'x, exp_bytes[i]);

    // 5: reset in the middle of data bit 4 of 0x5A
    uart_cnt = 16'd16;
    drive_bit(1'b1, 8);
    f0 = flag_cnt;
    b  = 8'h5A;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 16);
    drive_bit(b[4], 5);
    rst = 1'b1;
    drive_bit(b[4], 1);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_data", uart_data, 0);
    check("t5_rst_busy", uart_busy, 0);
    check("t5_rst_flag", uart_flag, 0);
    @(posedge clk);
    #1;
    drive_bit(1'b1, 30);
    check("t5_no_flag", flag_cnt - f0, 0);
    send_frame(8'h12, 16, 1'b1, 16, 1'b0, 1'b0);
    drive_bit(1'b1, 20);
    check("t5_flags_after", flag_cnt - f0, 1);
    check("t5_data_after", uart_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    // 6: even parity on 0x07; good parity bit is 1
    f0 = flag_cnt; p0 = perr_cnt;
    send_frame(8'h07, 16, 1'b1, 16, 1'b0, 1'b0);
    drive_bit(1'b1, 20);
    check("t6_good_flag", flag_cnt - f0, 1);
    check("t6_good_perr", perr_cnt - p0, 0);
    send_frame(8'h07, 16, 1'b1, 16, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check("t6_bad_flag", flag_cnt - f0, 2);
    check("t6_bad_perr", perr_cnt - p0, 1);
    check("t6_bad_data", uart_data, 8'h07);
`else
    p0 = perr_cnt;
`endif

    // Randomized frames: clean, framing errors with breaks, glitches, baud changes
    for (int f = 0; f < 40; f++) begin
      int n;
      int kind;
      n        = $urandom_range(4, 24);
      uart_cnt = 16'(n);
      drive_bit(1'b1, 4 + $urandom_range(0, 2 * n));
      kind = $urandom_range(0, 9);
      b    = W'($urandom);
      if (kind == 0) begin
        drive_bit(1'b0, $urandom_range(1, (n / 2) - 1));
        drive_bit(1'b1, n + 4);
      end else if (kind == 1) begin
        send_frame(b, n, 1'b0, n, 1'($urandom_range(0, 1)), 1'b0);
        drive_bit(1'b0, $urandom_range(0, 2 * n));
      end else begin
        send_frame(b, n, 1'b1, $urandom_range(n - n / 16, n), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0);
      end
    end
    drive_bit(1'b1, 60);
    if (!P) check("no_perr_without_parity", perr_cnt - p0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
